button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Per-bit debouncer for mechanical button/switch inputs that have already passed the
//  2-FF synchronizer. Samples each bit on a slow periodic tick and asserts the clean level
//  only after PULSE_CNT_MAX consecutive high samples. Output feeds user-I/O logic (FSMs, MMIO).
// PARAMETERS
//  WIDTH           1      number of independent input bits
//  SAMPLE_CNT_MAX  25000  clk cycles per sample tick (legal: >= 2)
//  PULSE_CNT_MAX   150    consecutive high samples required to assert output (legal: >= 1)
// PORTS
//  clk               input   1      single clock; all state updates on posedge clk
//  rst_n             input   1      asynchronous, active-low reset
//  glitchy_signal    input   WIDTH  synchronized but bouncing inputs (already in clk domain)
//  debounced_signal  output  WIDTH  clean level per bit
//  edge_pulse        output  WIDTH  1-cycle pulse on debounced rising edge (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, async): sample counter=0, all pulse counters=0, debounced_signal=0,
//    edge_pulse=0, edge history=0. Applies immediately, including mid-count.
//  - Sample timer: counter 0..SAMPLE_CNT_MAX-1, +1 per clk, wraps to 0. sample_tick is high
//    (comb.) while counter==SAMPLE_CNT_MAX-1, i.e. exactly one cycle per period. Shared by all bits.
//  - Per bit i, counter cnt[i] width $clog2(PULSE_CNT_MAX+1), updated only when sample_tick:
//      glitchy_signal[i]==0                       -> cnt[i] <= 0
//      glitchy_signal[i]==1, cnt[i]<PULSE_CNT_MAX -> cnt[i] <= cnt[i]+1
//      glitchy_signal[i]==1, cnt[i]==PULSE_CNT_MAX -> hold (saturate, never wraps)
//  - Between ticks the input is ignored entirely (glitches not coinciding with a tick are invisible).
//  - debounced_signal[i] = (cnt[i]==PULSE_CNT_MAX), comb. decode of registers (glitch-free).
//  - Assert latency: rises after the clk edge that registers the PULSE_CNT_MAX-th consecutive high
//    sample; worst case PULSE_CNT_MAX*SAMPLE_CNT_MAX cycles from input settling high.
//  - Deassert: falls after the edge registering the first low sample (<= SAMPLE_CNT_MAX cycles).
//  - A single low sample mid-accumulation restarts the count from 0.
//  - Bits fully independent; simultaneous activity on several bits has no interaction.
// CONFIGURATION
//  DEBOUNCE_EDGE_EN defined: prev[i] register captures debounced_signal[i] each clk;
//    edge_pulse[i] = debounced_signal[i] & ~prev[i] -> high exactly one cycle per rising edge,
//    coincident with the first cycle debounced_signal[i] is high. No pulse on falling edges.
//  DEBOUNCE_EDGE_EN undefined: no prev register; edge_pulse tied to {WIDTH{1'b0}}. Port list unchanged.
// STRUCTURE
//  - Shared header io_consts.vh: default SAMPLE_CNT_MAX/PULSE_CNT_MAX values and sim-scale
//    overrides (e.g. SIM_SAMPLE_CNT_MAX=4, SIM_PULSE_CNT_MAX=3) used by io_circuits benches.
//  - Sub-module debounce_sample_timer (params SAMPLE_CNT_MAX; ports clk, rst_n, sample_tick):
//    free-running wrap counter; reusable by other slow-sampling I/O blocks.
//  - Per-bit counters and edge logic in a generate loop over WIDTH.
// TESTING  (WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, DEBOUNCE_EDGE_EN defined unless noted)
//  1. In[0]=1 steady from reset release -> debounced[0] rises after edge 12, edge_pulse[0]=1
//     for exactly that one cycle; bit 1 stays 0 throughout.
//  2. In[0] high, low for 1 cycle at the 2nd tick, then high -> count restarts; debounced[0]
//     rises 3 ticks after the glitch tick, not before.
//  3. In[0] high with 1-cycle low glitches placed only between ticks -> identical timing to test 1.
//  4. After assertion, drive In[0]=0 -> debounced[0] falls after the next tick edge (<=4 cycles);
//     edge_pulse stays 0 on the fall; reassert -> needs 3 fresh ticks.
//  5. Assert rst_n=0 asynchronously while debounced[0]=1 and cnt mid-timer -> outputs 0 with no
//     clk edge; after release, timing restarts exactly as test 1.
//  6. Build without DEBOUNCE_EDGE_EN, rerun test 1 -> same debounced timing, edge_pulse==0 always.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// ============================================================================
// Module  : button_debouncer_pkg
// Purpose : Shared constants and width helpers for the button debouncer and
//           its sample timer. Holds both the silicon defaults and the
//           sim-scale values that the io_circuits benches use.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package button_debouncer_pkg;

  // Silicon defaults: at 50 MHz a 25000-cycle tick is 0.5 ms, and 150
  // samples give a 75 ms settle window.
  localparam int DEF_SAMPLE_CNT_MAX = 25000;
  localparam int DEF_PULSE_CNT_MAX  = 150;

  // Sim-scale values that keep bench run times short.
  localparam int SIM_SAMPLE_CNT_MAX = 4;
  localparam int SIM_PULSE_CNT_MAX  = 3;

  // Bits needed to hold the values 0..max_val. Never returns less than one
  // bit, so a degenerate max still gives a legal vector.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : button_debouncer_pkg

`default_nettype wire

// File: rtl/button_debouncer_sample_timer.sv
// ============================================================================
// Module  : debounce_sample_timer
// Purpose : Free-running wrap counter 0..SAMPLE_CNT_MAX-1. sample_tick is a
//           combinational decode of the last count, so it is high for exactly
//           one clk cycle per period. Reusable by any slow-sampling I/O block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_sample_timer
  import button_debouncer_pkg::*;
#(
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  output logic sample_tick
);

  // The counter only has to reach SAMPLE_CNT_MAX-1.
  localparam int TW = cnt_width(SAMPLE_CNT_MAX - 1);

  localparam logic [TW-1:0] c_last = TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [TW-1:0] c_one  = TW'(1);

  logic [TW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last   = (r_count == c_last);
  assign sample_tick = w_at_last;

  // Count up every cycle and wrap back to zero after the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_at_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_one;
    end
  end

endmodule : debounce_sample_timer

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module  : button_debouncer
// Purpose : Per-bit debouncer for already-synchronized button/switch inputs.
//           Each bit is sampled on a shared slow tick. Its clean level is
//           asserted only after PULSE_CNT_MAX consecutive high samples, and
//           a single low sample clears it.
// Options : DEBOUNCE_EDGE_EN - when defined, edge_pulse gives a one-cycle
//           pulse on each debounced rising edge. Otherwise edge_pulse is
//           tied low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam int CW = cnt_width(PULSE_CNT_MAX);

  localparam logic [CW-1:0] c_pulse_max = CW'(PULSE_CNT_MAX);
  localparam logic [CW-1:0] c_one       = CW'(1);

  logic w_sample_tick;

  // One timer is shared by every bit, so all bits sample on the same cycle.
  debounce_sample_timer #(
    .SAMPLE_CNT_MAX (SAMPLE_CNT_MAX)
  ) u_sample_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (w_sample_tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
      logic [CW-1:0] r_cnt;
      logic          w_full;

      // The clean level is a decode of registered state only, so it cannot
      // glitch.
      assign w_full                = (r_cnt == c_pulse_max);
      assign debounced_signal[gi]  = w_full;

      // Count consecutive high samples. A low sample restarts the count, and
      // the count saturates at the threshold. The input is ignored between
      // ticks.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_sample_tick) begin
          if (!glitchy_signal[gi]) begin
            r_cnt <= '0;
          end else if (!w_full) begin
            r_cnt <= r_cnt + c_one;
          end
        end
      end

`ifdef DEBOUNCE_EDGE_EN
      logic r_prev;

      // Remember last cycle's clean level to find rising edges.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= w_full;
        end
      end

      // The pulse lines up with the first cycle the clean level is high.
      assign edge_pulse[gi] = w_full & ~r_prev;
`else
      assign edge_pulse[gi] = 1'b0;
`endif
    end : g_bit
  endgenerate

endmodule : button_debouncer

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// Module  : tb_button_debouncer
// Purpose : Self-checking bench for button_debouncer with WIDTH=2,
//           SAMPLE_CNT_MAX=4 and PULSE_CNT_MAX=3. Directed scenarios are
//           followed by randomized stimulus. The reference model works from
//           elapsed time and run lengths of high samples.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debouncer;
  import button_debouncer_pkg::*;

  localparam int WIDTH = 2;
  localparam int SMAX  = SIM_SAMPLE_CNT_MAX;
  localparam int PMAX  = SIM_PULSE_CNT_MAX;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] glitchy_signal;
  logic [WIDTH-1:0] debounced_signal;
  logic [WIDTH-1:0] edge_pulse;

  button_debouncer #(
    .WIDTH          (WIDTH),
    .SAMPLE_CNT_MAX (SMAX),
    .PULSE_CNT_MAX  (PMAX)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .glitchy_signal   (glitchy_signal),
    .debounced_signal (debounced_signal),
    .edge_pulse       (edge_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  // m_cycles: clock edges since reset release.
  // m_run:    current run of consecutive high samples per bit, not capped.
  int               m_cycles;
  int               m_run [WIDTH];
  logic [WIDTH-1:0] m_deb;
  logic [WIDTH-1:0] m_prev;
  logic [WIDTH-1:0] m_edge;
  int               cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cycles = 0;
    for (int b = 0; b < WIDTH; b++) m_run[b] = 0;
    m_deb  = '0;
    m_prev = '0;
    m_edge = '0;
    cyc    = 0;
  endtask

  // The tick is high in every SMAX-th cycle after reset: cycles SMAX-1,
  // 2*SMAX-1, and so on. A bit is clean once its latest PMAX samples were
  // all high.
  task automatic model_edge(input logic [WIDTH-1:0] v);
    if ((m_cycles % SMAX) == SMAX - 1) begin
      for (int b = 0; b < WIDTH; b++) m_run[b] = v[b] ? m_run[b] + 1 : 0;
    end
    m_cycles++;
    for (int b = 0; b < WIDTH; b++) m_deb[b] = (m_run[b] >= PMAX);
    m_edge = EDGE_EN ? (m_deb & ~m_prev) : '0;
    m_prev = m_deb;
  endtask

  // Drive one cycle: inputs change at the negedge, the DUT clocks them in,
  // and the outputs are compared at the following negedge.
  task automatic step(input logic [WIDTH-1:0] v);
    glitchy_signal = v;
    @(posedge clk);
    model_edge(v);
    cyc++;
    @(negedge clk);
    check("debounced", 32'(debounced_signal), 32'(m_deb));
    check("edge_pulse", 32'(edge_pulse), 32'(m_edge));
  endtask

  // Assert reset between clock edges and confirm the outputs clear at once.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_deb", 32'(debounced_signal), 32'd0);
    check("async_rst_edge", 32'(edge_pulse), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  int rise_at;
  int pulses;
  int n;
  logic [WIDTH-1:0] v;
  int hold [WIDTH];
  logic [WIDTH-1:0] level;

  initial begin
    rst_n          = 1'b0;
    glitchy_signal = '0;
    model_reset();
    #1;
    check("reset_deb", 32'(debounced_signal), 32'd0);
    check("reset_edge", 32'(edge_pulse), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Scenario 1: bit 0 held high from reset release.
    rise_at = -1;
    pulses  = 0;
    for (int i = 0; i < 16; i++) begin
      step(2'b01);
      if (debounced_signal[0] && rise_at < 0) rise_at = cyc;
      if (edge_pulse[0]) pulses++;
      check("bit1_quiet", 32'(debounced_signal[1]), 32'd0);
    end
    check("s1_rise_edge", 32'(rise_at), 32'd12);
    check("s1_pulses", 32'(pulses), EDGE_EN ? 32'd1 : 32'd0);

    // Scenario 4: drop the input, expect the fall within one period, then
    // reassert and expect three fresh ticks before the clean level returns.
    n = 0;
    while (debounced_signal[0] && n < 8) begin
      step(2'b00);
      n++;
    end
    check("s4_fall_le_period", 32'(n <= SMAX), 32'd1);
    repeat (3) step(2'b00);
    rise_at = -1;
    for (int i = 0; i < 16; i++) begin
      step(2'b01);
      if (debounced_signal[0] && rise_at < 0) rise_at = i + 1;
    end
    check("s4_reassert_ge_2ticks", 32'(rise_at > 2 * SMAX), 32'd1);

    // Scenario 5: asynchronous reset while the clean level is high and the
    // timer is mid-count, then repeat scenario 1 timing.
    step(2'b01);
    check("s5_pre_deb", 32'(debounced_signal[0]), 32'd1);
    async_reset();
    rise_at = -1;
    for (int i = 0; i < 14; i++) begin
      step(2'b01);
      if (debounced_signal[0] && rise_at < 0) rise_at = cyc;
    end
    check("s5_rise_edge", 32'(rise_at), 32'd12);

    // Scenario 2: a one-cycle low that lands on the second tick.
    async_reset();
    rise_at = -1;
    for (int i = 0; i < 24; i++) begin
      v = (cyc == 2 * SMAX - 1) ? 2'b00 : 2'b01;
      step(v);
      if (debounced_signal[0] && rise_at < 0) rise_at = cyc;
    end
    check("s2_restart_rise", 32'(rise_at), 32'(5 * SMAX));

    // Scenario 3: low glitches that only fall between ticks.
    async_reset();
    rise_at = -1;
    for (int i = 0; i < 16; i++) begin
      v = ((cyc % SMAX) == 1) ? 2'b00 : 2'b01;
      step(v);
      if (debounced_signal[0] && rise_at < 0) rise_at = cyc;
    end
    check("s3_between_ticks", 32'(rise_at), 32'd12);

    // Randomized phase: each bit holds a level for a random stretch, with
    // occasional single-cycle flips, and async resets are added at random.
    async_reset();
    for (int b = 0; b < WIDTH; b++) begin
      hold[b]  = 0;
      level[b] = 1'b0;
    end
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (hold[b] == 0) begin
          level[b] = 1'($urandom_range(0, 1));
          hold[b]  = int'($urandom_range(1, 30));
        end
        hold[b]--;
        v[b] = ($urandom_range(0, 9) == 0) ? ~level[b] : level[b];
      end
      step(v);
      if ($urandom_range(0, 799) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_button_debouncer

`default_nettype wire
